// File: rtl/dlx_global_pkg.sv
// Shared DLX pipeline types: opcode classes, register addresses, forwarding selects
// and the pipeline-controller state encoding.
package dlx_global_pkg;

   typedef enum logic [3:0] {
      NOP    = 4'd0,
      RR_ALU = 4'd1,
      IM_ALU = 4'd2,
      BRANCH = 4'd3,
      LOAD   = 4'd4,
      STORE  = 4'd5,
      JUMP   = 4'd6,
      TRAP   = 4'd7
   } opcode_class;

   typedef logic [4:0] reg_adr;

   typedef enum logic [1:0] {
      FWDSEL_REGFILE        = 2'd0,
      FWDSEL_EX_MEM_ALU_OUT = 2'd1
   } fwd_select;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      HALT  = 2'd2,
      ERR   = 2'd3
   } ctrl_state_e;

   function automatic logic uses_rs1(input opcode_class c);
      return c inside {RR_ALU, IM_ALU, BRANCH, LOAD, STORE};
   endfunction

   function automatic logic uses_rs2(input opcode_class c);
      return c inside {RR_ALU, STORE};
   endfunction

endpackage

// File: rtl/dlx_hazard_detect.sv
// Combinational operand-use / destination-match logic for the ID stage:
// load-use hazard, branch-compare hazard and operand-A forwarding select.
module dlx_hazard_detect
   import dlx_global_pkg::*;
(
   input  opcode_class i_id_opcode_class,
   input  reg_adr      i_id_ir_rs1,
   input  reg_adr      i_id_ir_rs2,
   input  opcode_class i_id_ex_opcode_class,
   input  reg_adr      i_id_ex_reg_rd,
   input  logic        i_id_ex_reg_wen,
   input  opcode_class i_ex_mem_opcode_class,
   input  reg_adr      i_ex_mem_reg_rd,
   input  logic        i_ex_mem_reg_wen,
   output logic        o_load_use,
   output logic        o_br_hazard,
   output fwd_select   o_fwd_sel
);

   logic w_rs1_used;
   logic w_rs2_used;
   logic w_id_ex_hits_rs1;
   logic w_id_ex_hits_rs2;
   logic w_ex_mem_hits_rs1;

   assign w_rs1_used = uses_rs1(i_id_opcode_class);
   assign w_rs2_used = uses_rs2(i_id_opcode_class);

   // r0 is hard-wired to zero, so it can never carry a dependency
   assign w_id_ex_hits_rs1  = i_id_ex_reg_wen  && (i_id_ex_reg_rd  != '0) && (i_id_ex_reg_rd  == i_id_ir_rs1);
   assign w_id_ex_hits_rs2  = i_id_ex_reg_wen  && (i_id_ex_reg_rd  != '0) && (i_id_ex_reg_rd  == i_id_ir_rs2);
   assign w_ex_mem_hits_rs1 = i_ex_mem_reg_wen && (i_ex_mem_reg_rd != '0) && (i_ex_mem_reg_rd == i_id_ir_rs1);

   assign o_load_use = (i_id_ex_opcode_class == LOAD) &&
                       ((w_rs1_used && w_id_ex_hits_rs1) || (w_rs2_used && w_id_ex_hits_rs2));

   // The ID-stage compare only has an EX/MEM ALU bypass; anything in EX, or a load in MEM, must wait
   assign o_br_hazard = (i_id_opcode_class == BRANCH) &&
                        (w_id_ex_hits_rs1 || ((i_ex_mem_opcode_class == LOAD) && w_ex_mem_hits_rs1));

   assign o_fwd_sel = (w_rs1_used && w_ex_mem_hits_rs1 && (i_ex_mem_opcode_class != LOAD))
                      ? FWDSEL_EX_MEM_ALU_OUT : FWDSEL_REGFILE;

endmodule

// File: rtl/dlx_pipe_ctrl.sv
// DLX 5-stage pipeline controller: hazard stalls, cache freeze, flush/PC enable,
// trap/illegal drain-and-stop sequencing, and saturating stall/freeze statistics.
module dlx_pipe_ctrl
   import dlx_global_pkg::*;
#(
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 32,
   parameter int DC_TIMEOUT   = 1024
)(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  opcode_class      i_id_opcode_class,
   input  reg_adr           i_id_ir_rs1,
   input  reg_adr           i_id_ir_rs2,
   input  logic             i_id_cond,
   input  logic             i_id_halt,
   input  logic             i_id_illegal_instr,
   input  opcode_class      i_id_ex_opcode_class,
   input  reg_adr           i_id_ex_reg_rd,
   input  logic             i_id_ex_reg_wen,
   input  opcode_class      i_ex_mem_opcode_class,
   input  reg_adr           i_ex_mem_reg_rd,
   input  logic             i_ex_mem_reg_wen,
   input  logic             i_dc_busy,
   output logic             o_stall,
   output logic             o_dc_wait,
   output logic             o_pc_en,
   output logic             o_if_flush,
   output fwd_select        o_id_a_fwd_sel,
   output logic             o_halted,
   output logic             o_error,
   output logic             o_dc_timeout,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_freeze_cnt
);

   localparam int DRN_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
   localparam int RUN_W = (DC_TIMEOUT > 1) ? $clog2(DC_TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(DC_TIMEOUT);
   localparam logic [DRN_W-1:0] DRN_LAST  = (DRAIN_CYCLES > 2) ? DRN_W'(DRAIN_CYCLES - 2) : '0;

   ctrl_state_e      r_state;
   logic [DRN_W-1:0] r_drain_cnt;
   logic             r_cause_ill;
   logic             r_halted;
   logic             r_error;
   logic             r_dc_timeout;
   logic [RUN_W-1:0] r_busy_run;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_freeze_cnt;

   logic      w_load_use;
   logic      w_br_hazard;
   logic      w_hazard_stall;
   logic      w_accept;
   fwd_select w_fwd_sel;

   dlx_hazard_detect u_hazard (
      .i_id_opcode_class     (i_id_opcode_class),
      .i_id_ir_rs1           (i_id_ir_rs1),
      .i_id_ir_rs2           (i_id_ir_rs2),
      .i_id_ex_opcode_class  (i_id_ex_opcode_class),
      .i_id_ex_reg_rd        (i_id_ex_reg_rd),
      .i_id_ex_reg_wen       (i_id_ex_reg_wen),
      .i_ex_mem_opcode_class (i_ex_mem_opcode_class),
      .i_ex_mem_reg_rd       (i_ex_mem_reg_rd),
      .i_ex_mem_reg_wen      (i_ex_mem_reg_wen),
      .o_load_use            (w_load_use),
      .o_br_hazard           (w_br_hazard),
      .o_fwd_sel             (w_fwd_sel)
   );

   assign w_hazard_stall = (r_state == RUN) && !i_dc_busy && (w_load_use || w_br_hazard);
   // A trap/illegal is only taken once nothing ahead of it is stalling or frozen
   assign w_accept       = (r_state == RUN) && !i_dc_busy && !w_hazard_stall &&
                           (i_id_halt || i_id_illegal_instr);

   always_comb begin
      o_dc_wait  = i_dc_busy;
      o_stall    = 1'b0;
      o_pc_en    = 1'b0;
      o_if_flush = 1'b0;
      if (!i_dc_busy) begin
         if (r_state != RUN) begin
            o_stall    = 1'b1;
            o_if_flush = 1'b1;
         end else if (w_hazard_stall) begin
            o_stall = 1'b1;
         end else if (w_accept) begin
            o_if_flush = 1'b1;
         end else begin
            o_pc_en    = 1'b1;
            o_if_flush = i_id_cond;
         end
      end
   end

   assign o_id_a_fwd_sel = w_fwd_sel;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= RUN;
         r_drain_cnt <= '0;
         r_cause_ill <= 1'b0;
         r_halted    <= 1'b0;
         r_error     <= 1'b0;
      end else if (!i_dc_busy) begin
         case (r_state)
            RUN: begin
               if (w_accept) begin
                  r_state     <= DRAIN;
                  r_drain_cnt <= '0;
                  r_cause_ill <= i_id_illegal_instr;
               end
            end
            DRAIN: begin
               // The acceptance cycle is the first drain cycle, so stop one count early
               if (r_drain_cnt == DRN_LAST) begin
                  r_state  <= r_cause_ill ? ERR : HALT;
                  r_halted <= !r_cause_ill;
                  r_error  <= r_cause_ill;
               end else begin
                  r_drain_cnt <= r_drain_cnt + DRN_W'(1);
               end
            end
            default: r_state <= r_state;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stall_cnt  <= '0;
         r_freeze_cnt <= '0;
      end else begin
         if (w_hazard_stall && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
         if (i_dc_busy && (r_freeze_cnt != CNT_MAX)) begin
            r_freeze_cnt <= r_freeze_cnt + CNT_W'(1);
         end
      end
   end

   // Run length saturates at the limit; with DC_TIMEOUT=0 it never leaves zero
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_busy_run   <= '0;
         r_dc_timeout <= 1'b0;
      end else begin
         if (!i_dc_busy) begin
            r_busy_run <= '0;
         end else if (r_busy_run != RUN_LIMIT) begin
            r_busy_run <= r_busy_run + RUN_W'(1);
         end
         if ((DC_TIMEOUT != 0) && i_dc_busy && (r_busy_run == RUN_LIMIT - RUN_W'(1))) begin
            r_dc_timeout <= 1'b1;
         end
      end
   end

   assign o_halted     = r_halted;
   assign o_error      = r_error;
   assign o_dc_timeout = r_dc_timeout;
   assign o_stall_cnt  = r_stall_cnt;
   assign o_freeze_cnt = r_freeze_cnt;

endmodule

// File: tb/tb_dlx_pipe_ctrl.sv
// Self-checking bench for dlx_pipe_ctrl: directed vector table, hand-written
// multi-cycle sequences and randomized stimulus against a behavioural model.
module tb_dlx_pipe_ctrl;
   import dlx_global_pkg::*;

   localparam int DRAIN = 3;
   localparam int CW    = 4;
   localparam int TO    = 8;
   localparam int CMAX  = (1 << CW) - 1;

   logic        clk;
   logic        rst_n;
   opcode_class id_cls;
   reg_adr      rs1, rs2;
   logic        id_cond, id_halt, id_ill;
   opcode_class ex_cls;
   reg_adr      ex_rd;
   logic        ex_wen;
   opcode_class mem_cls;
   reg_adr      mem_rd;
   logic        mem_wen;
   logic        dc_busy;
   logic        stall, dc_wait, pc_en, if_flush, halted, error, dc_timeout;
   fwd_select   fwd;
   logic [CW-1:0] stall_cnt, freeze_cnt;

   int checks   = 0;
   int failures = 0;

   // behavioural model: phase 0 running, 1 draining, 2 halted, 3 errored
   int m_phase, m_left, m_stall_cnt, m_freeze_cnt, m_busy_run;
   bit m_ill, m_to;

   dlx_pipe_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW), .DC_TIMEOUT(TO)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_id_opcode_class(id_cls), .i_id_ir_rs1(rs1), .i_id_ir_rs2(rs2),
      .i_id_cond(id_cond), .i_id_halt(id_halt), .i_id_illegal_instr(id_ill),
      .i_id_ex_opcode_class(ex_cls), .i_id_ex_reg_rd(ex_rd), .i_id_ex_reg_wen(ex_wen),
      .i_ex_mem_opcode_class(mem_cls), .i_ex_mem_reg_rd(mem_rd), .i_ex_mem_reg_wen(mem_wen),
      .i_dc_busy(dc_busy),
      .o_stall(stall), .o_dc_wait(dc_wait), .o_pc_en(pc_en), .o_if_flush(if_flush),
      .o_id_a_fwd_sel(fwd), .o_halted(halted), .o_error(error), .o_dc_timeout(dc_timeout),
      .o_stall_cnt(stall_cnt), .o_freeze_cnt(freeze_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      opcode_class id_c; reg_adr r1; reg_adr r2; logic cond;
      opcode_class ex_c; reg_adr ex_d; logic ex_w;
      opcode_class mem_c; reg_adr mem_d; logic mem_w; logic busy;
      logic e_stall; logic e_pc; logic e_flush; logic e_wait; fwd_select e_fwd;
   } vec_t;

   vec_t vecs [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic set_idle();
      id_cls = NOP; rs1 = '0; rs2 = '0; id_cond = 0; id_halt = 0; id_ill = 0;
      ex_cls = NOP; ex_rd = '0; ex_wen = 0; mem_cls = NOP; mem_rd = '0; mem_wen = 0;
      dc_busy = 0;
   endtask

   task automatic apply_vec(input vec_t v);
      id_cls = v.id_c; rs1 = v.r1; rs2 = v.r2; id_cond = v.cond; id_halt = 0; id_ill = 0;
      ex_cls = v.ex_c; ex_rd = v.ex_d; ex_wen = v.ex_w;
      mem_cls = v.mem_c; mem_rd = v.mem_d; mem_wen = v.mem_w; dc_busy = v.busy;
   endtask

   task automatic model_reset();
      m_phase = 0; m_left = 0; m_ill = 0; m_stall_cnt = 0; m_freeze_cnt = 0;
      m_busy_run = 0; m_to = 0;
   endtask

   function automatic bit reads_a(opcode_class c);
      return c == RR_ALU || c == IM_ALU || c == BRANCH || c == LOAD || c == STORE;
   endfunction

   function automatic bit reads_b(opcode_class c);
      return c == RR_ALU || c == STORE;
   endfunction

   function automatic bit model_hazard();
      bit lu, bh;
      lu = ex_cls == LOAD && ex_wen && ex_rd != 0 &&
           ((reads_a(id_cls) && ex_rd == rs1) || (reads_b(id_cls) && ex_rd == rs2));
      bh = id_cls == BRANCH && rs1 != 0 &&
           ((ex_wen && ex_rd == rs1) || (mem_cls == LOAD && mem_wen && mem_rd == rs1));
      return lu || bh;
   endfunction

   function automatic fwd_select model_fwd();
      if (reads_a(id_cls) && rs1 != 0 && mem_wen && mem_rd == rs1 && mem_cls != LOAD)
         return FWDSEL_EX_MEM_ALU_OUT;
      return FWDSEL_REGFILE;
   endfunction

   // Compare all outputs against the model at the falling edge, then advance one clock
   task automatic tick();
      bit e_stall, e_pc, e_fl, haz, acc;
      @(negedge clk);
      haz = model_hazard();
      e_stall = 0; e_pc = 0; e_fl = 0; acc = 0;
      if (!dc_busy) begin
         if (m_phase != 0) begin e_stall = 1; e_fl = 1; end
         else if (haz) e_stall = 1;
         else if (id_halt || id_ill) begin e_fl = 1; acc = 1; end
         else begin e_pc = 1; e_fl = id_cond; end
      end
      chk("stall", stall, e_stall);
      chk("dc_wait", dc_wait, dc_busy);
      chk("pc_en", pc_en, e_pc);
      chk("if_flush", if_flush, e_fl);
      chk("fwd_sel", fwd, model_fwd());
      chk("halted", halted, m_phase == 2);
      chk("error", error, m_phase == 3);
      chk("dc_timeout", dc_timeout, m_to);
      chk("stall_cnt", stall_cnt, m_stall_cnt);
      chk("freeze_cnt", freeze_cnt, m_freeze_cnt);
      if (dc_busy) begin
         if (m_freeze_cnt < CMAX) m_freeze_cnt++;
         m_busy_run++;
         if (m_busy_run == TO) m_to = 1;
      end else begin
         m_busy_run = 0;
         if (m_phase == 0 && haz && m_stall_cnt < CMAX) m_stall_cnt++;
         if (acc) begin
            m_phase = 1; m_left = DRAIN - 1; m_ill = id_ill;
         end else if (m_phase == 1) begin
            m_left--;
            if (m_left == 0) m_phase = m_ill ? 3 : 2;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset asserted mid-cycle; registered outputs must clear at once
   task automatic pulse_reset();
      set_idle();
      #2 rst_n = 0;
      #1;
      chk("rst_halted", halted, 0);
      chk("rst_error", error, 0);
      chk("rst_timeout", dc_timeout, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_freeze_cnt", freeze_cnt, 0);
      model_reset();
      @(posedge clk);
      #2 rst_n = 1;
   endtask

   initial begin
      vecs[0]  = '{RR_ALU, 5'd1, 5'd3, 1'b0, LOAD,   5'd3, 1'b1, NOP,    5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, FWDSEL_REGFILE};
      vecs[1]  = '{BRANCH, 5'd5, 5'd0, 1'b0, NOP,    5'd0, 1'b0, IM_ALU, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FWDSEL_EX_MEM_ALU_OUT};
      vecs[2]  = '{BRANCH, 5'd0, 5'd0, 1'b0, NOP,    5'd0, 1'b0, IM_ALU, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FWDSEL_REGFILE};
      vecs[3]  = '{BRANCH, 5'd5, 5'd0, 1'b0, IM_ALU, 5'd5, 1'b1, NOP,    5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, FWDSEL_REGFILE};
      vecs[4]  = '{BRANCH, 5'd5, 5'd0, 1'b0, NOP,    5'd0, 1'b0, LOAD,   5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, FWDSEL_REGFILE};
      vecs[5]  = '{IM_ALU, 5'd1, 5'd3, 1'b0, LOAD,   5'd3, 1'b1, NOP,    5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FWDSEL_REGFILE};
      vecs[6]  = '{STORE,  5'd1, 5'd3, 1'b0, LOAD,   5'd3, 1'b1, NOP,    5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, FWDSEL_REGFILE};
      vecs[7]  = '{LOAD,   5'd0, 5'd0, 1'b0, LOAD,   5'd0, 1'b1, NOP,    5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FWDSEL_REGFILE};
      vecs[8]  = '{RR_ALU, 5'd3, 5'd1, 1'b0, LOAD,   5'd3, 1'b0, NOP,    5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FWDSEL_REGFILE};
      vecs[9]  = '{JUMP,   5'd0, 5'd0, 1'b1, NOP,    5'd0, 1'b0, NOP,    5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, FWDSEL_REGFILE};
      vecs[10] = '{BRANCH, 5'd5, 5'd0, 1'b1, IM_ALU, 5'd5, 1'b1, NOP,    5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, FWDSEL_REGFILE};
      vecs[11] = '{RR_ALU, 5'd1, 5'd3, 1'b0, LOAD,   5'd3, 1'b1, NOP,    5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, FWDSEL_REGFILE};
      vecs[12] = '{RR_ALU, 5'd4, 5'd0, 1'b0, IM_ALU, 5'd4, 1'b1, RR_ALU, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FWDSEL_EX_MEM_ALU_OUT};
      vecs[13] = '{NOP,    5'd4, 5'd0, 1'b0, NOP,    5'd0, 1'b0, RR_ALU, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FWDSEL_REGFILE};
      vecs[14] = '{RR_ALU, 5'd4, 5'd0, 1'b0, NOP,    5'd0, 1'b0, LOAD,   5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FWDSEL_REGFILE};

      rst_n = 0;
      set_idle();
      model_reset();
      @(posedge clk);
      #1;
      pulse_reset();

      for (int i = 0; i < 15; i++) begin
         apply_vec(vecs[i]);
         #2;
         chk($sformatf("vec%0d_stall", i), stall, vecs[i].e_stall);
         chk($sformatf("vec%0d_pc_en", i), pc_en, vecs[i].e_pc);
         chk($sformatf("vec%0d_flush", i), if_flush, vecs[i].e_flush);
         chk($sformatf("vec%0d_wait", i), dc_wait, vecs[i].e_wait);
         chk($sformatf("vec%0d_fwd", i), fwd, vecs[i].e_fwd);
         $display("vec %0d stall=%0b pc_en=%0b flush=%0b wait=%0b fwd=%0d", i, stall, pc_en, if_flush, dc_wait, fwd);
         tick();
      end

      // load-use: one stall cycle, then the bubble clears it
      pulse_reset();
      apply_vec(vecs[0]);
      tick();
      chk("lu_stall_cnt", stall_cnt, 1);
      ex_cls = NOP; ex_rd = '0; ex_wen = 0;
      #2 chk("lu_released", stall, 0);
      tick();
      $display("seq load-use stall_cnt=%0d", stall_cnt);

      // freeze dominates a pending load-use hazard
      pulse_reset();
      apply_vec(vecs[0]);
      dc_busy = 1;
      for (int k = 0; k < 4; k++) begin
         #2;
         chk("frz_wait", dc_wait, 1);
         chk("frz_stall", stall, 0);
         tick();
      end
      dc_busy = 0;
      #2;
      chk("frz_then_stall", stall, 1);
      chk("frz_freeze_cnt", freeze_cnt, 4);
      chk("frz_stall_cnt", stall_cnt, 0);
      tick();
      $display("seq freeze freeze_cnt=%0d stall_cnt=%0d", freeze_cnt, stall_cnt);

      // trap: flush on acceptance, halted exactly DRAIN cycles later
      pulse_reset();
      id_cls = TRAP; id_halt = 1;
      #2 chk("trap_flush", if_flush, 1);
      for (int k = 1; k <= DRAIN; k++) begin
         tick();
         if (k == 1) set_idle();
         chk("trap_halt_latency", halted, k == DRAIN);
      end
      for (int k = 0; k < 3; k++) begin
         #2 chk("halt_pc_en", pc_en, 0);
         tick();
      end
      $display("seq trap halted=%0b error=%0b", halted, error);
      pulse_reset();

      // simultaneous trap and illegal: illegal wins
      id_cls = TRAP; id_halt = 1; id_ill = 1;
      for (int k = 1; k <= DRAIN; k++) begin
         tick();
         if (k == 1) set_idle();
      end
      chk("both_error", error, 1);
      chk("both_halted", halted, 0);
      $display("seq illegal halted=%0b error=%0b", halted, error);

      // freeze inside DRAIN delays the error by the frozen cycles
      pulse_reset();
      id_halt = 1; id_ill = 1;
      tick();
      set_idle();
      tick();
      dc_busy = 1;
      tick();
      tick();
      chk("drainfrz_error_early", error, 0);
      dc_busy = 0;
      tick();
      chk("drainfrz_error", error, 1);
      $display("seq drain-freeze error=%0b", error);

      // dc_busy timeout is sticky until reset
      pulse_reset();
      dc_busy = 1;
      for (int k = 1; k <= TO; k++) begin
         tick();
         chk("to_edge", dc_timeout, k == TO);
      end
      dc_busy = 0;
      tick();
      chk("to_sticky", dc_timeout, 1);
      $display("seq timeout dc_timeout=%0b freeze_cnt=%0d", dc_timeout, freeze_cnt);
      pulse_reset();

      // randomized traffic against the model
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 79) == 0) pulse_reset();
         id_cls  = opcode_class'($urandom_range(0, 7));
         rs1     = reg_adr'($urandom_range(0, 3));
         rs2     = reg_adr'($urandom_range(0, 3));
         id_cond = ($urandom_range(0, 3) == 0);
         id_halt = ($urandom_range(0, 29) == 0);
         id_ill  = ($urandom_range(0, 49) == 0);
         ex_cls  = opcode_class'($urandom_range(0, 7));
         ex_rd   = reg_adr'($urandom_range(0, 3));
         ex_wen  = $urandom_range(0, 1);
         mem_cls = opcode_class'($urandom_range(0, 7));
         mem_rd  = reg_adr'($urandom_range(0, 3));
         mem_wen = $urandom_range(0, 1);
         dc_busy = ($urandom_range(0, 3) == 0);
         tick();
      end
      $display("random done stall_cnt=%0d freeze_cnt=%0d", stall_cnt, freeze_cnt);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
